cmp_seq_ctrl: RTL and testbench

// - Sequencer that performs a multi-byte unsigned magnitude compare of two operands A and B.
// - Uses one external 8-bit open-collector comparator with the active-low P=Q / P>Q pinout.
// - Each cycle it drives one byte pair MSB-first and samples the comparator's active-low outputs.
// - Stops on the first unequal byte and reports eq/gt/lt plus a done strobe.
// - Sits between a host that issues start and the shared comparator.

---
 rtl/cmp_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_cmp_seq_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_seq_ctrl.sv
// Multi-byte unsigned magnitude compare sequencer driving one external
// 8-bit open-collector comparator (active-low P=Q / P>Q outputs).
// Bytes are presented MSB-first, one pair per cycle; the sequence stops at
// the first unequal byte and reports eq/gt/lt (or err) with a done strobe.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; results of the last compare held
//   CMP   | comparator enabled, byte idx presented, sampling each edge
//   FIN   | one-cycle done strobe, comparator disabled
module cmp_seq_ctrl #(
    parameter int NBYTES = 4,
    parameter int IDXW   = 4
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                start,
    input  logic [8*NBYTES-1:0] a,
    input  logic [8*NBYTES-1:0] b,
    output logic                g_n,
    output logic [7:0]          p_out,
    output logic [7:0]          q_out,
    input  logic                p_eq_q_n,
    input  logic                p_gt_q_n,
    output logic                busy,
    output logic                done,
    output logic                eq,
    output logic                gt,
    output logic                lt,
    output logic                err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NBYTES - 1);

    state_t              state_q;
    logic [IDXW-1:0]     idx_q;
    logic [IDXW-1:0]     idx_d;
    logic [8*NBYTES-1:0] a_q;
    logic [8*NBYTES-1:0] b_q;
    logic [7:0]          p_q;
    logic [7:0]          q_q;
    logic [7:0]          p_d;
    logic [7:0]          q_d;
    logic                g_n_q;
    logic                busy_q;
    logic                done_q;
    logic                eq_q;
    logic                gt_q;
    logic                lt_q;
    logic                err_q;

    // Next lower byte pair, presented when the current pair compares equal.
    always_comb begin
        idx_d = idx_q - 1'b1;
        p_d   = a_q[8*int'(idx_d) +: 8];
        q_d   = b_q[8*int'(idx_d) +: 8];
    end

    // Sequencer FSM with registered comparator drive and status outputs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            q_q     <= '0;
            g_n_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        idx_q   <= IDX_TOP;
                        p_q     <= a[8*(NBYTES-1) +: 8];
                        q_q     <= b[8*(NBYTES-1) +: 8];
                        g_n_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        eq_q    <= 1'b0;
                        gt_q    <= 1'b0;
                        lt_q    <= 1'b0;
                        err_q   <= 1'b0;
                        state_q <= S_CMP;
                    end
                end
                S_CMP: begin
                    // The edge samples the comparator's view of the pair
                    // presented during the cycle that just ended.
                    if (!p_eq_q_n && idx_q != '0 && p_gt_q_n) begin
                        idx_q <= idx_d;
                        p_q   <= p_d;
                        q_q   <= q_d;
                    end else begin
                        if (!p_eq_q_n && !p_gt_q_n) begin
                            err_q <= 1'b1;
                        end else if (!p_eq_q_n) begin
                            eq_q <= 1'b1;
                        end else if (!p_gt_q_n) begin
                            gt_q <= 1'b1;
                        end else begin
                            lt_q <= 1'b1;
                        end
                        g_n_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_FIN;
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign g_n   = g_n_q;
    assign p_out = p_q;
    assign q_out = q_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign eq    = eq_q;
    assign gt    = gt_q;
    assign lt    = lt_q;
    assign err   = err_q;

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Bench for cmp_seq_ctrl: open-collector comparator model with pullups,
// directed scenarios plus randomized compares checked against a byte-wise
// reference model of the expected result and latency.
module tb_cmp_seq_ctrl;

    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          clr;
    logic          start;
    logic [31:0]   a;
    logic [31:0]   b;
    logic          fault;
    wire           g_n;
    wire  [7:0]    p_out;
    wire  [7:0]    q_out;
    wire           eq_n_w;
    wire           gt_n_w;
    wire           busy;
    wire           done;
    wire           eq;
    wire           gt;
    wire           lt;
    wire           err;

    int            checks = 0;
    int            errors = 0;
    int            done_cyc;
    int            gn_low;
    logic [7:0]    pseq[$];
    logic [7:0]    qseq[$];

    cmp_seq_ctrl #(.NBYTES(NB), .IDXW(4)) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .a        (a),
        .b        (b),
        .g_n      (g_n),
        .p_out    (p_out),
        .q_out    (q_out),
        .p_eq_q_n (eq_n_w),
        .p_gt_q_n (gt_n_w),
        .busy     (busy),
        .done     (done),
        .eq       (eq),
        .gt       (gt),
        .lt       (lt),
        .err      (err)
    );

    // External comparator: open-collector outputs pulled high when released.
    pullup (eq_n_w);
    pullup (gt_n_w);
    assign eq_n_w = (fault || (!g_n && p_out == q_out)) ? 1'b0 : 1'bz;
    assign gt_n_w = (fault || (!g_n && p_out >  q_out)) ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Number of bytes the sequencer must examine: position of the first
    // differing byte counted from the MSB, or all of them when equal.
    function automatic int exp_bytes(input logic [31:0] x, input logic [31:0] y);
        for (int i = NB - 1; i >= 0; i--) begin
            if (x[8*i +: 8] != y[8*i +: 8]) return NB - i;
        end
        return NB;
    endfunction

    // Expected {err,lt,gt,eq} from plain unsigned comparison.
    function automatic logic [3:0] exp_res(input logic [31:0] x, input logic [31:0] y);
        if (x == y) return 4'b0001;
        if (x > y)  return 4'b0010;
        return 4'b0100;
    endfunction

    // Follows one compare after its start edge, sampling at negedges.
    task automatic watch(input int fault_cyc, input int abort_cyc, input bit scr);
        done_cyc = -1;
        gn_low   = 0;
        pseq.delete();
        qseq.delete();
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (!g_n) begin
                gn_low++;
                pseq.push_back(p_out);
                qseq.push_back(q_out);
            end
            if (done) begin
                done_cyc = c;
                start    = 1'b0;
                chk("busy_at_done", {31'd0, busy}, 32'd0);
                break;
            end
            chk("busy_in_cmp", {31'd0, busy}, 32'd1);
            if (c == abort_cyc) begin
                clr = 1'b1;
                return;
            end
            fault = (c == fault_cyc);
            if (scr) begin
                a     = $urandom;
                b     = $urandom;
                start = 1'($urandom_range(0, 1));
            end
        end
        fault = 1'b0;
    endtask

    task automatic launch(input logic [31:0] x, input logic [31:0] y, input bit hold);
        @(negedge clk);
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    task automatic run(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input int fault_cyc, input bit scr);
        int k;
        logic [3:0] r;
        launch(x, y, 1'b0);
        watch(fault_cyc, 0, scr);
        k = (fault_cyc > 0) ? fault_cyc : exp_bytes(x, y);
        r = (fault_cyc > 0) ? 4'b1000 : exp_res(x, y);
        chk({tag, "_done_cyc"}, done_cyc, k + 1);
        chk({tag, "_gn_low"}, gn_low, k);
        chk({tag, "_result"}, {28'd0, err, lt, gt, eq}, {28'd0, r});
    endtask

    initial begin
        int k1;
        int seen_done;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] x2;
        logic [31:0] y2;

        clr   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        fault = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ctl", {27'd0, g_n, busy, done, 3'd0}, {27'd0, 1'b1, 1'b0, 1'b0, 3'd0});
        chk("reset_res", {28'd0, err, lt, gt, eq}, 32'd0);
        chk("reset_pq", {16'd0, p_out, q_out}, 32'd0);
        clr = 1'b0;

        run("equal", 32'hDEADBEEF, 32'hDEADBEEF, 0, 1'b0);
        @(negedge clk);
        chk("equal_hold", {28'd0, err, lt, gt, eq}, 32'd1);

        run("msb", 32'h80000000, 32'h7FFFFFFF, 0, 1'b0);
        chk("msb_p", {24'd0, pseq[0]}, 32'h80);
        chk("msb_q", {24'd0, qseq[0]}, 32'h7F);

        run("lsb", 32'h12345600, 32'h12345601, 0, 1'b0);
        chk("lsb_pseq", {pseq[0], pseq[1], pseq[2], pseq[3]}, 32'h12345600);

        run("fault", 32'h11223344, 32'h11223344, 2, 1'b0);

        // Abort on the second CMP cycle.
        launch(32'h01020304, 32'h01020304, 1'b0);
        watch(0, 2, 1'b0);
        #1;
        chk("abort_ctl", {29'd0, g_n, busy, done}, {29'd0, 1'b1, 1'b0, 1'b0});
        chk("abort_pq", {16'd0, p_out, q_out}, 32'd0);
        seen_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        chk("abort_no_done", seen_done, 0);
        clr = 1'b0;
        run("post_abort", 32'h00000010, 32'h00000020, 0, 1'b0);

        // start held high: back-to-back compares with operand recapture.
        x  = 32'hA5000000; y  = 32'hA4FFFFFF;
        x2 = 32'h00000001; y2 = 32'h00000002;
        launch(x, y, 1'b1);
        a = x2;
        b = y2;
        watch(0, 0, 1'b0);
        start = 1'b1;
        k1 = exp_bytes(x, y);
        chk("held1_done_cyc", done_cyc, k1 + 1);
        chk("held1_result", {28'd0, err, lt, gt, eq}, {28'd0, exp_res(x, y)});
        @(negedge clk);
        chk("held_idle_gap", {30'd0, busy, g_n}, 32'd1);
        @(posedge clk);
        #1;
        watch(0, 0, 1'b0);
        start = 1'b0;
        chk("held2_done_cyc", done_cyc, exp_bytes(x2, y2) + 1);
        chk("held2_result", {28'd0, err, lt, gt, eq}, {28'd0, exp_res(x2, y2)});

        // Randomized compares; operands and start are scrambled mid-compare.
        for (int n = 0; n < 30; n++) begin
            int pos;
            x   = $urandom;
            y   = x;
            pos = $urandom_range(0, NB);
            if (pos < NB) begin
                y[8*pos +: 8] = y[8*pos +: 8] ^ 8'($urandom_range(1, 255));
                for (int i = 0; i < pos; i++) y[8*i +: 8] = 8'($urandom);
            end
            run("rand", x, y, 0, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
